// File: rtl/quad2pos.sv
// Quadrature decoder: synchronizes and filters phase A/B, then accumulates a
// signed position with step/direction pulses and a sticky illegal-transition flag.
module quad2pos #(
  parameter int FILTER = 3,
  parameter int WIDTH  = 8
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic             Steer_A_I,
  input  logic             Steer_B_I,
  input  logic             Clr_I,
  output logic [WIDTH-1:0] Pos_O,
  output logic             Step_O,
  output logic             Dir_O,
  output logic             Err_O
);

  localparam logic [3:0] FILT = 4'(FILTER);

  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] cand;
  logic [1:0] q_acc;
  logic [1:0] q_prev;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       accept;
  logic       is_fwd;
  logic       is_rev;
  logic       is_ill;

  function automatic logic [1:0] fwd_of(input logic [1:0] s);
    case (s)
      2'b00:   fwd_of = 2'b10;
      2'b10:   fwd_of = 2'b11;
      2'b11:   fwd_of = 2'b01;
      default: fwd_of = 2'b00;
    endcase
  endfunction

  // Acceptance keys off the next count so Q moves on the very edge the
  // candidate completes its FILTER-th matching sample.
  always_comb begin
    cnt_nxt = cnt;
    if (sync2 != cand)
      cnt_nxt = 4'd1;
    else if (cnt < FILT)
      cnt_nxt = cnt + 4'd1;
    accept = (cnt_nxt == FILT) && (sync2 != q_acc);
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      cand   <= '0;
      cnt    <= '0;
      q_acc  <= '0;
      q_prev <= '0;
    end else begin
      sync1  <= {Steer_A_I, Steer_B_I};
      sync2  <= sync1;
      cand   <= sync2;
      cnt    <= cnt_nxt;
      q_prev <= q_acc;
      if (accept)
        q_acc <= sync2;
    end
  end

  always_comb begin
    is_fwd = (q_acc == fwd_of(q_prev));
    is_rev = (q_prev == fwd_of(q_acc));
    is_ill = ((q_acc ^ q_prev) == 2'b11);
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      Pos_O  <= '0;
      Step_O <= 1'b0;
      Dir_O  <= 1'b1;
      Err_O  <= 1'b0;
    end else begin
      Step_O <= is_fwd | is_rev;
      if (is_fwd | is_rev)
        Dir_O <= is_fwd;
      if (Clr_I)
        Pos_O <= '0;
      else if (is_fwd)
        Pos_O <= Pos_O + WIDTH'(1);
      else if (is_rev)
        Pos_O <= Pos_O - WIDTH'(1);
      if (Clr_I)
        Err_O <= 1'b0;
      else if (is_ill)
        Err_O <= 1'b1;
    end
  end

endmodule

// File: tb/tb_quad2pos.sv
// Directed bench for quad2pos (FILTER=3, WIDTH=8): latency, glitch rejection,
// wrap, clear interaction, illegal transitions and reset behaviour.
module tb_quad2pos;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       steer_a;
  logic       steer_b;
  logic       clr;
  logic [7:0] pos;
  logic       step;
  logic       dir;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;
  logic cur_a = 1'b0;
  logic cur_b = 1'b0;

  quad2pos #(.FILTER(3), .WIDTH(8)) dut (
    .CLK       (clk_sys),
    .Reset_n   (rst_n),
    .Steer_A_I (steer_a),
    .Steer_B_I (steer_b),
    .Clr_I     (clr),
    .Pos_O     (pos),
    .Step_O    (step),
    .Dir_O     (dir),
    .Err_O     (err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
  endtask

  function automatic logic [1:0] next_fwd(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] next_rev(input logic [1:0] p);
    case (p)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  // Drives the pins, holds them for a fixed number of edges and records
  // the edge index of the first Step_O pulse and the pulse count.
  task automatic go(input logic a, input logic b, input int hold,
                    output int first, output int pulses);
    cur_a   = a;
    cur_b   = b;
    steer_a = a;
    steer_b = b;
    first   = -1;
    pulses  = 0;
    for (int i = 1; i <= hold; i++) begin
      tick();
      if (step) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic move(input bit rev, input bit chk, input string tag);
    logic [1:0] nx;
    int f, p;
    nx = rev ? next_rev({cur_a, cur_b}) : next_fwd({cur_a, cur_b});
    go(nx[1], nx[0], 8, f, p);
    if (chk) begin
      check({tag, "_lat"}, f, 6);
      check({tag, "_pulses"}, p, 1);
      check({tag, "_dir"}, dir, rev ? 0 : 1);
    end
  endtask

  initial begin
    int f, p1, p2;
    logic [1:0] nx;
    rst_n = 1'b0; steer_a = 1'b0; steer_b = 1'b0; clr = 1'b0;
    repeat (2) tick();
    check("rst_pos", pos, 0);
    check("rst_step", step, 0);
    check("rst_dir", dir, 1);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    repeat (4) tick();

    for (int k = 0; k < 4; k++) move(1'b0, 1'b1, "fwd4");
    check("fwd4_pos", pos, 4);
    move(1'b1, 1'b1, "rev1");
    check("rev1_pos", pos, 3);
    move(1'b0, 1'b1, "fwd5");
    check("fwd5_pos", pos, 4);

    go(1'b1, 1'b0, 2, f, p1);
    go(1'b0, 1'b0, 10, f, p2);
    check("glitch2_pulses", p1 + p2, 0);
    check("glitch2_pos", pos, 4);
    check("glitch2_err", err, 0);
    go(1'b1, 1'b0, 4, f, p1);
    go(1'b0, 1'b0, 14, f, p2);
    check("glitch4_pulses", p1 + p2, 2);
    check("glitch4_pos", pos, 4);
    check("glitch4_dir", dir, 0);

    for (int k = 0; k < 123; k++) move(1'b0, 1'b0, "");
    check("pre_wrap_pos", pos, 8'h7F);
    move(1'b0, 1'b1, "wrap_up");
    check("wrap_up_pos", pos, 8'h80);
    check("wrap_up_err", err, 0);
    move(1'b1, 1'b1, "wrap_dn");
    check("wrap_dn_pos", pos, 8'h7F);

    nx = next_rev({cur_a, cur_b});
    cur_a = nx[1]; cur_b = nx[0];
    steer_a = nx[1]; steer_b = nx[0];
    repeat (5) tick();
    clr = 1'b1;
    tick();
    check("clrstep_step", step, 1);
    check("clrstep_dir", dir, 0);
    check("clrstep_pos", pos, 0);
    clr = 1'b0;
    tick();
    check("clrstep_after_step", step, 0);
    check("clrstep_after_pos", pos, 0);
    repeat (4) tick();

    move(1'b0, 1'b1, "post_clr");
    check("post_clr_pos", pos, 1);
    go(~cur_a, ~cur_b, 10, f, p1);
    check("ill_pulses", p1, 0);
    check("ill_err", err, 1);
    check("ill_pos", pos, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("ill_clr_err", err, 0);
    check("ill_clr_pos", pos, 0);
    move(1'b0, 1'b1, "track");
    check("track_pos", pos, 1);
    while ({cur_a, cur_b} != 2'b00) move(1'b0, 1'b0, "");
    check("prerst_pos_nonzero", (pos != 0), 1);

    steer_a = 1'b1; steer_b = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_pos", pos, 0);
    check("midrst_step", step, 0);
    check("midrst_dir", dir, 1);
    check("midrst_err", err, 0);
    steer_a = 1'b0;
    tick();
    rst_n = 1'b1;
    go(1'b0, 1'b0, 12, f, p1);
    check("midrst_pulses", p1, 0);
    check("midrst_pos_after", pos, 0);
    check("midrst_err_after", err, 0);

    rst_n = 1'b0;
    steer_a = 1'b1; steer_b = 1'b1;
    tick();
    rst_n = 1'b1;
    go(1'b1, 1'b1, 12, f, p1);
    check("rel11_pulses", p1, 0);
    check("rel11_err", err, 1);
    check("rel11_pos", pos, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/quad2pos.md
QUAD2POS -- requirements
Module: quad2pos

Interface
REQ-001 Parameter FILTER, default 3, meaning consecutive CLK samples a synchronized input pair must hold before acceptance (legal range 1..15).
REQ-002 Parameter WIDTH, default 8, meaning position counter width in bits.
REQ-003 CLK  input  1  single system clock; all state updates on rising edge.
REQ-004 Reset_n  input  1  asynchronous, active-low reset.
REQ-005 Steer_A_I  input  1  quadrature phase A, asynchronous to CLK.
REQ-006 Steer_B_I  input  1  quadrature phase B, asynchronous to CLK.
REQ-007 Clr_I  input  1  synchronous clear of position and error flag, active high.
REQ-008 Pos_O  output  WIDTH  accumulated position, two's complement, wraps modulo 2^WIDTH.
REQ-009 Step_O  output  1  one-cycle pulse per accepted legal transition.
REQ-010 Dir_O  output  1  direction of last legal step (1 = +1, 0 = -1); holds between steps.
REQ-011 Err_O  output  1  sticky flag: an illegal (double-bit) transition was accepted.

Function
REQ-012 Each input passes through a 2-flop synchronizer; only synchronized value S = {A,B} is used downstream.
REQ-013 Filter: counter tracks consecutive cycles S equals candidate C; on S != C, C<=S and counter<=1; counter saturates at FILTER.
REQ-014 Accepted state Q updates to C on the cycle counter reaches FILTER with C != Q; Q never changes otherwise.
REQ-015 Forward sequence of Q (+1): 00->10->11->01->00; reverse sequence (-1): 00->01->11->10->00.
REQ-016 Legal Q change registers one cycle later: Step_O=1 for exactly one cycle, Dir_O set per REQ-015, Pos_O +/-1 on that same edge.
REQ-017 Illegal Q change (both bits differ, e.g. 00->11): Err_O<=1, Step_O stays 0, Pos_O and Dir_O unchanged; Q still takes new value.
REQ-018 Total latency: stable pin change to Step_O high = FILTER+3 CLK edges (2 sync + FILTER filter + 1 output register); FILTER=3 gives 6.
REQ-019 Input pulses shorter than FILTER synchronized cycles are discarded without any output effect.
REQ-020 Pos_O wrap: 2^(WIDTH-1)-1 +1 -> -2^(WIDTH-1); -2^(WIDTH-1) -1 -> 2^(WIDTH-1)-1; no saturation, no flag.
REQ-021 Clr_I=1: Pos_O<=0 and Err_O<=0 on that edge, overriding a simultaneous step's position update; Step_O and Dir_O still reflect the step.
REQ-022 Clr_I does not disturb synchronizer, filter, or Q; motion during clear continues to be tracked afterward.
REQ-023 Maximum decodable rate: one accepted transition per FILTER+1 cycles; faster input loses steps or flags Err_O, never corrupts state.

Reset
REQ-024 Reset_n low asynchronously forces: synchronizer flops, C, Q to 00; filter counter 0; Pos_O 0; Step_O 0; Dir_O 1; Err_O 0.
REQ-025 First Q after reset release derives from filtered inputs; if inputs are not 00 at release, the first acceptance out of Q=00 is evaluated per REQ-015/017 (e.g. 11 sets Err_O).
REQ-026 Reset asserted mid-sequence discards partially filtered samples; no Step_O pulse is emitted at or after release for pre-reset motion.

Verification
REQ-027 Inputs 00 held, then four forward steps each held 8 cycles (10,11,01,00), FILTER=3 -> four Step_O pulses, each 6 cycles after its pin change, Dir_O=1, Pos_O=4.
REQ-028 From Pos_O=127 (WIDTH=8), one forward step -> Pos_O=-128 (0x80), Step_O pulse, Err_O=0; one reverse step -> Pos_O=127.
REQ-029 Steer_A_I glitch high for 2 cycles then low, FILTER=3 -> no Step_O, Pos_O unchanged, Err_O=0; glitch of 4 cycles -> one +1 step then one -1 step.
REQ-030 Both inputs 00->11 simultaneously, held 10 cycles -> Err_O=1, Step_O never high, Pos_O unchanged; Clr_I pulse -> Err_O=0, Pos_O=0.
REQ-031 Clr_I asserted on the same edge a reverse step registers -> Pos_O=0 (not -1), Step_O=1, Dir_O=0.
REQ-032 Reset_n pulsed low 1 cycle two cycles after a pin change -> all outputs at reset values; no Step_O for that change afterward (inputs returned to 00 before release).
